// File: rtl/bigsdram_responder.sv
// Device-side SDRAM responder for the BigSDRAM controller: decodes commands, tracks open rows,
// stores write bursts and returns read bursts after CAS latency. Define BIGSDRAM_RESPONDER_CHECK_EN for protocol checks.
module bigsdram_responder #(
  parameter int unsigned RowBits = 2,
  parameter int unsigned ColBits = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ddr_cke,
  input  logic        ddr_csn,
  input  logic        ddr_rasn,
  input  logic        ddr_casn,
  input  logic        ddr_wen,
  input  logic [1:0]  ddr_ba,
  input  logic [12:0] ddr_addr,
  input  logic [1:0]  ddr_dm,
  input  logic [15:0] ddr_dq_in,
  output logic [15:0] ddr_dq_out,
  output logic        ddr_dq_oe,
  output logic [3:0]  open_banks,
  output logic        err,
  output logic [2:0]  err_code
);
  localparam int unsigned AddrBits = 2 + RowBits + ColBits;
  localparam int unsigned Depth    = 1 << AddrBits;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  logic [15:0]         r_mem [Depth];
  logic [RowBits-1:0]  r_row [4];
  logic                r_cl3;
  logic [1:0]          r_bl_log;
  logic                r_rd_active;
  logic                r_wr_active;
  logic                r_rd_wait;
  logic [1:0]          r_bank;
  logic [1:0]          r_bbl_log;
  logic [RowBits-1:0]  r_brow;
  logic [ColBits-1:0]  r_bcol;
  logic [2:0]          r_cnt;

  logic                w_cmd_valid;
  cmd_e                w_cmd;
  logic                w_mode_ok;
  logic                w_err_hit;
  logic [2:0]          w_err_val;
  logic                w_do_act;
  logic                w_do_pre;
  logic                w_do_lmr;
  logic                w_do_rd;
  logic                w_do_wr;
  logic                w_last;
  logic [AddrBits-1:0] w_beat_addr;
  logic                w_unused;

  // Sequential burst column, wrapping inside the BL-aligned block
  function automatic logic [ColBits-1:0] burst_col(input logic [ColBits-1:0] col,
                                                   input logic [1:0] bl_log,
                                                   input logic [2:0] k);
    logic [ColBits-1:0] mask;
    mask = ColBits'((4'd1 << bl_log) - 4'd1);
    return (col & ~mask) | ((col + ColBits'(k)) & mask);
  endfunction

  assign w_cmd_valid = ddr_cke & ~ddr_csn;
  assign w_cmd       = cmd_e'({ddr_rasn, ddr_casn, ddr_wen});
  assign w_mode_ok   = ((ddr_addr[6:4] == 3'd2) || (ddr_addr[6:4] == 3'd3)) &&
                       (ddr_addr[2:0] != 3'd0) && (ddr_addr[2:0] <= 3'd3);
  assign w_last      = (r_cnt == 3'((4'd1 << r_bbl_log) - 4'd1));
  assign w_beat_addr = {r_bank, r_brow, burst_col(r_bcol, r_bbl_log, r_cnt)};
  assign w_unused    = ^ddr_addr;

  // Protocol error detection; an erroring command is dropped
  always_comb begin
    w_err_hit = 1'b0;
    w_err_val = 3'd0;
`ifdef BIGSDRAM_RESPONDER_CHECK_EN
    if (w_cmd_valid) begin
      case (w_cmd)
        CMD_ACT: begin
          if (open_banks[ddr_ba]) begin
            w_err_hit = 1'b1;
            w_err_val = 3'd1;
          end
        end
        CMD_RD, CMD_WR: begin
          if (r_rd_active || r_wr_active) begin
            w_err_hit = 1'b1;
            w_err_val = 3'd3;
          end else if (!open_banks[ddr_ba]) begin
            w_err_hit = 1'b1;
            w_err_val = 3'd2;
          end
        end
        CMD_REF: begin
          if (|open_banks) begin
            w_err_hit = 1'b1;
            w_err_val = 3'd4;
          end
        end
        CMD_LMR: begin
          if (ddr_ba == 2'd0) begin
            if (|open_banks) begin
              w_err_hit = 1'b1;
              w_err_val = 3'd4;
            end else if (!w_mode_ok) begin
              w_err_hit = 1'b1;
              w_err_val = 3'd5;
            end
          end
        end
        default: ;
      endcase
    end
`endif
  end

  assign w_do_act = w_cmd_valid && (w_cmd == CMD_ACT) && !w_err_hit;
  assign w_do_pre = w_cmd_valid && (w_cmd == CMD_PRE);
  assign w_do_lmr = w_cmd_valid && (w_cmd == CMD_LMR) && (ddr_ba == 2'd0) && w_mode_ok && !w_err_hit;
  assign w_do_rd  = w_cmd_valid && (w_cmd == CMD_RD) && !w_err_hit;
  assign w_do_wr  = w_cmd_valid && (w_cmd == CMD_WR) && !w_err_hit;

  // Storage and per-bank row latches are not reset
  always_ff @(posedge clock) begin
    if (!reset && ddr_cke) begin
      if (r_wr_active) begin
        if (!ddr_dm[0]) r_mem[w_beat_addr][7:0]  <= ddr_dq_in[7:0];
        if (!ddr_dm[1]) r_mem[w_beat_addr][15:8] <= ddr_dq_in[15:8];
      end
      if (w_do_act) r_row[ddr_ba] <= ddr_addr[RowBits-1:0];
    end
  end

  // Burst engine and command state; later assignments let a new burst override the current one
  always_ff @(posedge clock) begin
    if (reset) begin
      ddr_dq_out  <= 16'd0;
      ddr_dq_oe   <= 1'b0;
      open_banks  <= 4'd0;
      err         <= 1'b0;
      err_code    <= 3'd0;
      r_cl3       <= 1'b0;
      r_bl_log    <= 2'd1;
      r_rd_active <= 1'b0;
      r_wr_active <= 1'b0;
      r_rd_wait   <= 1'b0;
      r_bank      <= 2'd0;
      r_bbl_log   <= 2'd1;
      r_brow      <= '0;
      r_bcol      <= '0;
      r_cnt       <= 3'd0;
    end else if (ddr_cke) begin
      ddr_dq_oe <= 1'b0;
      if (r_rd_active) begin
        if (r_rd_wait) begin
          r_rd_wait <= 1'b0;
        end else begin
          ddr_dq_out <= r_mem[w_beat_addr];
          ddr_dq_oe  <= 1'b1;
          r_cnt      <= r_cnt + 3'd1;
          if (w_last) r_rd_active <= 1'b0;
        end
      end
      if (r_wr_active) begin
        r_cnt <= r_cnt + 3'd1;
        if (w_last) r_wr_active <= 1'b0;
      end

      if (w_err_hit) begin
        err      <= 1'b1;
        err_code <= w_err_val;
      end
      if (w_do_act) open_banks[ddr_ba] <= 1'b1;
      if (w_do_pre) begin
        if (ddr_addr[10]) open_banks <= 4'd0;
        else              open_banks[ddr_ba] <= 1'b0;
      end
      if (w_do_lmr) begin
        r_cl3    <= (ddr_addr[6:4] == 3'd3);
        r_bl_log <= ddr_addr[1:0];
      end
      if (w_do_rd || w_do_wr) begin
        r_bank      <= ddr_ba;
        r_brow      <= r_row[ddr_ba];
        r_bcol      <= ddr_addr[ColBits-1:0];
        r_bbl_log   <= r_bl_log;
        r_cnt       <= 3'd0;
        r_rd_active <= w_do_rd;
        r_wr_active <= w_do_wr;
        r_rd_wait   <= r_cl3;
      end
    end
  end
endmodule

// File: doc/bigsdram_responder.md
# bigsdram_responder

Single-clock, cycle-accurate SDRAM device-side responder for the BigSDRAM controller: it decodes the command bus the controller drives, tracks open rows per bank, stores write data and returns read data after the programmed CAS latency. It sits opposite the controller in simulation and loopback test builds, replacing the external DDR part on the `ddr_*` pins. Data moves one 16-bit word per `clock` cycle (SDR-equivalent view of the DDR bus); `ddr_dq` is split into in/out/enable.

## Interface
- `RowBits`, 2, row address bits stored (low bits of `ddr_addr` on ACTIVE)
- `ColBits`, 4, column address bits stored (low bits of `ddr_addr` on READ/WRITE); must be >= 3
- `clock`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `ddr_cke`  in  1  clock enable; 0 freezes all state
- `ddr_csn`, `ddr_rasn`, `ddr_casn`, `ddr_wen`  in  1 each  command strobes, active-low
- `ddr_ba`  in  2  bank address
- `ddr_addr`  in  13  row/column/mode address; bit 10 = precharge-all
- `ddr_dm`  in  2  write byte mask, 1 = byte not written ([1] covers dq[15:8])
- `ddr_dq_in`  in  16  write data
- `ddr_dq_out`  out  16  read data, registered
- `ddr_dq_oe`  out  1  high exactly on cycles read data is valid
- `open_banks`  out  4  bit b = bank b has a row open
- `err`  out  1  sticky protocol error
- `err_code`  out  3  code of most recent error

## Operation
- Storage: 4 × 2^RowBits × 2^ColBits words of 16 bits, index {ba, row, col}. Contents undefined after power-up; reset does not clear storage.
- Command, decoded only when `ddr_cke`=1 and `ddr_csn`=0, from {rasn,casn,wen}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH (no-op, legal only with all banks closed), 000 LOAD MODE. `ddr_csn`=1 = NOP.
- ACTIVE: latch row for `ddr_ba`, set `open_banks[ba]`.
- PRECHARGE: clear `open_banks[ba]`, or all bits if `ddr_addr[10]`=1. Precharging a closed bank is legal.
- LOAD MODE (`ddr_ba`=0): CL = `ddr_addr[6:4]` (2 or 3), BL = `ddr_addr[2:0]` (1→2, 2→4, 3→8). Other values: error, mode unchanged. `ddr_ba`≠0: ignored.
- Burst addressing sequential, wrapping inside BL-aligned block: col_k = {col[ColBits-1:log2 BL], (col[log2 BL-1:0]+k) mod BL}.
- READ at cycle t: word k on `ddr_dq_out` with `ddr_dq_oe`=1 at t+CL+k, k=0..BL-1.
- WRITE at cycle t: word k sampled from `ddr_dq_in` at t+1+k, per-byte masked by `ddr_dm` of that cycle.
- One burst at a time. READ/WRITE while a burst (including read latency pipeline) is active: ignored, error.
- Error codes: 1 ACTIVE to open bank, 2 READ/WRITE to closed bank, 3 READ/WRITE during burst, 4 LOAD MODE/REFRESH with bank open, 5 bad mode value. Erroneous command has no effect; `err` set, `err_code` updated.
- `ddr_cke`=0: no command decode, burst counters, CL pipeline and outputs hold.

## Timing
- Reset values: `ddr_dq_out`=0, `ddr_dq_oe`=0, `open_banks`=0, `err`=0, `err_code`=0, CL=2, BL=2, no burst active.
- Reset mid-burst: burst aborted next edge; no further writes, `ddr_dq_oe`=0.
- Write and read of the same address in the same cycle impossible (single burst).
- PRECHARGE of a bank during its own burst: burst completes with latched row.
- Read after write to same word: first READ accepted after write burst ends returns new data.
- Simultaneous error and command on same cycle: error wins, command dropped.

## Configuration
- `BIGSDRAM_RESPONDER_CHECK_EN` defined: protocol checks as above, `err`/`err_code` live, illegal commands dropped.
- Undefined: no checks; `err`=0 and `err_code`=0 constant; ACTIVE to open bank reopens, READ/WRITE to closed bank uses last latched row, READ/WRITE during burst restarts burst, bad mode values leave mode unchanged.

## Test plan
- Reset, LOAD MODE addr=0x022 (CL2,BL4), ACTIVE ba=1 row=2, WRITE col=4 with 0x1111..0x4444, dm=0, READ col=4 → dq_oe high 4 cycles starting READ+2, data 0x1111,0x2222,0x3333,0x4444.
- BL4 READ col=6 after above write → order col6,7,4,5 = 0x3333,0x4444,0x1111,0x2222.
- WRITE 0xABCD with dm=2'b10 over 0x1111 → read returns 0x11CD.
- CL=3 BL=8 via addr=0x033 → first word at READ+3, dq_oe high 8 cycles.
- (CHECK_EN) READ to closed bank 3 → err=1, err_code=2, dq_oe stays 0; ACTIVE twice to bank 0 → err_code=1.
- ddr_cke low 3 cycles mid read burst → dq_out/dq_oe hold, burst resumes and completes with all BL words; reset mid-burst → dq_oe=0 next cycle, open_banks=0.
